// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target receive path
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_rx_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchronizer plus glitch filter for one open-drain bus line
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic line_i,
  output logic line_f
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   line_s;

  assign line_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
    end
  end

  // Count consecutive samples that disagree with the filtered level; any
  // agreeing sample restarts the count, so short pulses never get through.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      line_f <= 1'b1;
    end else if (line_s == line_f) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT_LEN - 1)) begin
      cnt    <= '0;
      line_f <= line_s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - I2C target write-only receive front-end with byte strobe output
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h58,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_first,
  output logic       frame_start,
  output logic       frame_stop,
  output logic       busy
);

  logic scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, start_c, stop_c;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rstn(rstn), .line_i(scl_i), .line_f(scl_f)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rstn(rstn), .line_i(sda_i), .line_f(sda_f)
  );

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
  assign sda_o    = 1'b0;

  i2c_rx_state_t state_q, state_d;
  logic [7:0] shreg, shreg_d, m_data_d;
  logic [3:0] bitcnt, bitcnt_d;
  logic       first_flag, first_d, matched, matched_d;
  logic       sda_t_d, m_valid_d, m_first_d, fstart_d, fstop_d, busy_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus conditions are checked before the per-state handling so START/STOP
  // always win over a coincident clock edge.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg;
    bitcnt_d  = bitcnt;
    first_d   = first_flag;
    matched_d = matched;
    sda_t_d   = sda_t;
    m_data_d  = m_data;
    m_valid_d = 1'b0;
    m_first_d = 1'b0;
    fstart_d  = 1'b0;
    fstop_d   = 1'b0;
    busy_d    = busy;
    if (stop_c) begin
      state_d   = ST_IDLE;
      sda_t_d   = 1'b1;
      busy_d    = 1'b0;
      fstop_d   = matched;
      matched_d = 1'b0;
    end else if (start_c) begin
      state_d   = ST_ADDR;
      bitcnt_d  = 4'd0;
      sda_t_d   = 1'b1;
      busy_d    = 1'b1;
      matched_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (scl_rise && bitcnt != 4'd8) begin
            shreg_d  = {shreg[6:0], sda_f};
            bitcnt_d = bitcnt + 4'd1;
          end else if (scl_fall && bitcnt == 4'd8) begin
            if (state_q == ST_DATA) begin
              m_data_d  = shreg;
              m_valid_d = 1'b1;
              m_first_d = first_flag;
              first_d   = 1'b0;
              sda_t_d   = 1'b0;
              state_d   = ST_DATA_ACK;
            end else if (shreg[7:1] == ADDR && shreg[0] == I2C_RW_WRITE) begin
              sda_t_d   = 1'b0;
              fstart_d  = 1'b1;
              matched_d = 1'b1;
              state_d   = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            sda_t_d  = 1'b1;
            bitcnt_d = 4'd0;
            state_d  = ST_DATA;
            if (state_q == ST_ADDR_ACK) first_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      shreg       <= 8'h00;
      bitcnt      <= 4'd0;
      first_flag  <= 1'b0;
      matched     <= 1'b0;
      sda_t       <= 1'b1;
      m_data      <= 8'h00;
      m_valid     <= 1'b0;
      m_first     <= 1'b0;
      frame_start <= 1'b0;
      frame_stop  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      scl_q       <= scl_f;
      sda_q       <= sda_f;
      shreg       <= shreg_d;
      bitcnt      <= bitcnt_d;
      first_flag  <= first_d;
      matched     <= matched_d;
      sda_t       <= sda_t_d;
      m_data      <= m_data_d;
      m_valid     <= m_valid_d;
      m_first     <= m_first_d;
      frame_start <= fstart_d;
      frame_stop  <= fstop_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - self-checking bench for i2c_target_rx with a bus-level master
module tb_i2c_target_rx;

  localparam logic [6:0] ADDR = 7'h58;

  logic clk = 1'b0, rstn = 1'b0;
  logic scl_m = 1'b1, sda_m = 1'b1, g_scl = 1'b0, g_sda = 1'b0;
  logic sda_bus, scl_i, sda_i;
  logic sda_o, sda_t, m_valid, m_first, frame_start, frame_stop, busy;
  logic [7:0] m_data;

  assign sda_bus = sda_m & (sda_t | sda_o);
  assign scl_i   = scl_m ^ g_scl;
  assign sda_i   = sda_bus ^ g_sda;

  always #5 clk = ~clk;

  i2c_target_rx #(.ADDR(ADDR), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk(clk), .rstn(rstn), .scl_i(scl_i), .sda_i(sda_i),
    .sda_o(sda_o), .sda_t(sda_t), .m_data(m_data), .m_valid(m_valid),
    .m_first(m_first), .frame_start(frame_start), .frame_stop(frame_stop), .busy(busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       f;
  } rx_t;

  typedef struct {
    logic [7:0]  ab;
    int          n;
    logic [31:0] data;
    int          q;
    logic        exp_ack;
    int          exp_nv;
    int          exp_fs;
    int          exp_fp;
  } vec_t;

  int errors = 0, checks = 0;
  int q = 20;
  rx_t mon_q[$];
  int n_fs = 0, n_fp = 0, n_wide = 0;
  logic prev_v = 1'b0;
  logic [7:0] tx [4];
  logic ack_a [5];
  int q0, fs0, fp0;
  vec_t vecs [4];

  always @(negedge clk) begin
    if (m_valid) mon_q.push_back('{d: m_data, f: m_first});
    if (frame_start) n_fs++;
    if (frame_stop) n_fp++;
    if (m_valid && prev_v) n_wide++;
    prev_v = m_valid;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq(q);
    scl_m = 1'b1; wq(q);
    sda_m = 1'b0; wq(q);
    scl_m = 1'b0; wq(q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq(q);
    scl_m = 1'b1; wq(q);
    sda_m = 1'b1; wq(2 * q);
  endtask

  task automatic send_bit(input logic b, input logic gl);
    sda_m = b; wq(q);
    scl_m = 1'b1;
    if (gl) begin
      wq(q / 2); g_sda = 1'b1; wq(1); g_sda = 1'b0; wq(2 * q - q / 2 - 1);
    end else wq(2 * q);
    scl_m = 1'b0;
    if (gl) begin
      wq(q / 2); g_scl = 1'b1; wq(1); g_scl = 1'b0; wq(q - q / 2 - 1);
    end else wq(q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gl_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == gl_bit);
    sda_m = 1'b1; wq(q);
    scl_m = 1'b1; wq(q);
    ack = sda_bus; wq(q);
    scl_m = 1'b0; wq(q);
  endtask

  task automatic run_frame(input logic [7:0] ab, input int n, input logic do_stop);
    logic a;
    bus_start();
    send_byte(ab, -1, a);
    ack_a[0] = a;
    for (int i = 0; i < n; i++) begin
      send_byte(tx[i], -1, a);
      ack_a[i + 1] = a;
    end
    if (do_stop) begin
      bus_stop();
      wq(10);
    end
  endtask

  task automatic snap();
    q0 = mon_q.size(); fs0 = n_fs; fp0 = n_fp;
  endtask

  function automatic logic model_match(input logic [7:0] ab);
    return (ab[7:1] == ADDR) && (ab[0] == 1'b0);
  endfunction

  task automatic verify(input string tag, input logic exp_ack, input int n,
                        input int exp_nv, input int exp_fs, input int exp_fp);
    for (int i = 0; i <= n; i++) check({tag, "_ack"}, 32'(ack_a[i]), exp_ack ? 32'd0 : 32'd1);
    check({tag, "_nvalid"}, 32'(mon_q.size() - q0), 32'(exp_nv));
    for (int i = 0; i < exp_nv; i++) begin
      if (q0 + i < mon_q.size()) begin
        check({tag, "_data"}, 32'(mon_q[q0 + i].d), 32'(tx[i]));
        check({tag, "_first"}, 32'(mon_q[q0 + i].f), (i == 0) ? 32'd1 : 32'd0);
      end
    end
    check({tag, "_frame_start"}, 32'(n_fs - fs0), 32'(exp_fs));
    check({tag, "_frame_stop"}, 32'(n_fp - fp0), 32'(exp_fp));
  endtask

  initial begin
    logic a;
    logic [7:0] ab;
    int n;
    logic m;

    vecs[0] = '{ab: 8'hB0, n: 3, data: 32'h0066FF12, q: 250, exp_ack: 1'b1, exp_nv: 3, exp_fs: 1, exp_fp: 1};
    vecs[1] = '{ab: 8'hAA, n: 3, data: 32'h0077FF12, q: 20,  exp_ack: 1'b0, exp_nv: 0, exp_fs: 0, exp_fp: 0};
    vecs[2] = '{ab: 8'hB1, n: 2, data: 32'h00003412, q: 20,  exp_ack: 1'b0, exp_nv: 0, exp_fs: 0, exp_fp: 0};
    vecs[3] = '{ab: 8'hB0, n: 1, data: 32'h00000000, q: 20,  exp_ack: 1'b1, exp_nv: 1, exp_fs: 1, exp_fp: 1};

    wq(5);
    check("rst_sda_t", 32'(sda_t), 32'd1);
    check("rst_sda_o", 32'(sda_o), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_first", 32'(m_first), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_frame_stop", 32'(frame_stop), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    wq(10);

    for (int v = 0; v < 4; v++) begin
      q = vecs[v].q;
      for (int i = 0; i < 4; i++) tx[i] = vecs[v].data[8 * i +: 8];
      snap();
      run_frame(vecs[v].ab, vecs[v].n, 1'b0);
      check($sformatf("vec%0d_busy_before_stop", v), 32'(busy), 32'd1);
      bus_stop();
      wq(10);
      check($sformatf("vec%0d_busy_after_stop", v), 32'(busy), 32'd0);
      verify($sformatf("vec%0d", v), vecs[v].exp_ack, vecs[v].n,
             vecs[v].exp_nv, vecs[v].exp_fs, vecs[v].exp_fp);
    end

    // repeated START between two matched frames
    q = 20;
    snap();
    tx[0] = 8'hA5;
    run_frame(8'hB0, 1, 1'b0);
    check("rs_ack0", 32'(ack_a[0]), 32'd0);
    check("rs_ack1", 32'(ack_a[1]), 32'd0);
    tx[0] = 8'h3C;
    run_frame(8'hB0, 1, 1'b0);
    check("rs_busy_mid", 32'(busy), 32'd1);
    check("rs_frame_stop_mid", 32'(n_fp - fp0), 32'd0);
    bus_stop();
    wq(10);
    check("rs_nvalid", 32'(mon_q.size() - q0), 32'd2);
    if (mon_q.size() >= q0 + 2) begin
      check("rs_data0", 32'(mon_q[q0].d), 32'hA5);
      check("rs_first0", 32'(mon_q[q0].f), 32'd1);
      check("rs_data1", 32'(mon_q[q0 + 1].d), 32'h3C);
      check("rs_first1", 32'(mon_q[q0 + 1].f), 32'd1);
    end
    check("rs_frame_start", 32'(n_fs - fs0), 32'd2);
    check("rs_frame_stop", 32'(n_fp - fp0), 32'd1);

    // single-cycle glitches on both lines inside a data byte
    snap();
    tx[0] = 8'hC3;
    bus_start();
    send_byte(8'hB0, -1, a);
    ack_a[0] = a;
    send_byte(tx[0], 4, a);
    ack_a[1] = a;
    bus_stop();
    wq(10);
    verify("glitch", 1'b1, 1, 1, 1, 1);

    // reset while the address ACK is held on the bus
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(8'hB0 >> i, 1'b0);
    sda_m = 1'b1; wq(q);
    scl_m = 1'b1; wq(q);
    check("rstack_driven", 32'(sda_t), 32'd0);
    rstn = 1'b0;
    #1;
    check("rstack_released", 32'(sda_t), 32'd1);
    check("rstack_busy", 32'(busy), 32'd0);
    wq(5);
    rstn = 1'b1;
    scl_m = 1'b0; wq(q);
    bus_stop();
    wq(10);
    snap();
    tx[0] = 8'h5A; tx[1] = 8'h81;
    run_frame(8'hB0, 2, 1'b1);
    verify("after_rst", 1'b1, 2, 2, 1, 1);

    // randomized frames against the frame-level model
    for (int r = 0; r < 8; r++) begin
      ab = ($urandom_range(0, 1) == 0) ? 8'hB0 : 8'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
      m = model_match(ab);
      snap();
      run_frame(ab, n, 1'b1);
      check($sformatf("rnd%0d_busy", r), 32'(busy), 32'd0);
      verify($sformatf("rnd%0d", r), m, n, m ? n : 0, m ? 1 : 0, m ? 1 : 0);
    end

    check("m_valid_single_cycle", 32'(n_wide), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
# i2c_target_rx

I2C target (slave) receive front-end that sits directly upstream of the command logic inside `i2c_top` on I2C port 0. It:
- synchronizes and filters the external SCL/SDA lines;
- detects START, repeated START and STOP;
- matches a 7-bit write address and shifts in data bytes, ACKing each one;
- presents every received byte as a single-cycle strobe to downstream logic.

It never stretches the clock and has no backpressure.

## Interface
Parameters:
- `ADDR`, 7'h58, 7-bit target address this block responds to.
- `SYNC_STAGES`, 2, synchronizer depth on scl_i/sda_i (minimum 2).
- `FILT_LEN`, 3, glitch filter length in clk cycles; a line changes state only after FILT_LEN identical consecutive synchronized samples.

Ports:
- `clk`  in  1  system clock (100 MHz nominal).
- `rstn`  in  1  asynchronous, active-low reset.
- `scl_i`  in  1  raw SCL line level.
- `sda_i`  in  1  raw SDA line level.
- `sda_o`  out  1  SDA drive value; constant 0.
- `sda_t`  out  1  SDA tristate; 1 = released (input), 0 = drive low.
- `m_data`  out  8  received data byte.
- `m_valid`  out  1  one-cycle strobe; m_data is valid this cycle.
- `m_first`  out  1  qualifies m_valid; byte is the first after the address.
- `frame_start`  out  1  one-cycle pulse on an address match (write).
- `frame_stop`  out  1  one-cycle pulse on STOP if the frame was matched.
- `busy`  out  1  high from START until STOP.

## Operation
- Filtered lines are `scl_f` and `sda_f`. Both reset to 1.
- Events, derived from the filtered lines in the same cycle:
  - `scl_rise`, `scl_fall`: edges of scl_f.
  - START: sda_f falls while scl_f = 1.
  - STOP: sda_f rises while scl_f = 1.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: on START go to ADDR. bitcnt=0, busy=1.
  - ADDR: shift sda_f into shreg on each scl_rise, MSB first. On the scl_fall after the 8th bit:
    - shreg[7:1]==ADDR and shreg[0]==0 → ADDR_ACK, sda_t=0, frame_start pulses.
    - otherwise → IGNORE, sda_t stays 1 (NACK). Read requests are not supported.
  - ADDR_ACK: on the next scl_fall release SDA (sda_t=1) and go to DATA. bitcnt=0, first_flag=1.
  - DATA: shift on scl_rise. On the scl_fall after the 8th bit:
    - m_data=shreg, m_valid=1, m_first=first_flag.
    - first_flag=0, sda_t=0, go to DATA_ACK.
  - DATA_ACK: on the next scl_fall set sda_t=1 and go to DATA.
  - IGNORE: wait for START or STOP; sda_t=1 throughout.
- START in any non-IDLE state (repeated START) → ADDR. bitcnt cleared, sda_t=1. frame_stop does not pulse.
- STOP in any state → IDLE. sda_t=1, busy=0. frame_stop pulses if the frame reached ADDR_ACK; a partial byte is discarded.
- START/STOP take priority over bit shifting in the same cycle.

## Timing
- Reset values: sda_o=0, sda_t=1, m_data=0, m_valid=0, m_first=0, frame_start=0, frame_stop=0, busy=0, FSM=IDLE.
- Input latency: raw line to scl_f/sda_f = SYNC_STAGES + FILT_LEN cycles. Both lines have identical latency, so START/STOP ordering is preserved.
- m_valid and sda_t fall are registered outputs, asserted 1 cycle after the 8th-bit scl_fall is detected.
- The ACK is released 1 cycle after the 9th-bit scl_fall is detected. This holds SDA through the SCL low phase, which satisfies I2C hold time at 100 kHz and 400 kHz.
- m_valid is exactly one cycle wide; downstream must accept it unconditionally.
- Reset mid-frame: SDA is released asynchronously; the frame is lost.

## Structure
- The shared package `i2c_pkg` holds:
  - `typedef enum logic [2:0]` i2c_rx_state_t;
  - the constant `I2C_RW_WRITE = 1'b0`.
- Sub-module `i2c_line_filter`: synchronizer plus glitch filter, instantiated once each for SCL and SDA.
- FSM and shift register live in the top of this block.

## Test plan
- Frame addr 0x58 W, data 0x12, 0xFF, 0x66, STOP (100 kHz bit rate) → expected:
  - ACK on all 4 bytes;
  - m_valid ×3 with m_data 0x12 (m_first=1), then 0xFF and 0x66;
  - frame_start ×1, frame_stop ×1, busy low after STOP.
- Frame addr 0x55 W, data 0x12, 0xFF, 0x77 → expected:
  - NACK (SDA stays high) on the address byte;
  - no m_valid, no frame_start, no frame_stop.
- Addr 0x58 with R bit set → NACK, state IGNORE, no outputs until STOP.
- Addr 0x58 W, data 0xA5, repeated START, addr 0x58 W, data 0x3C, STOP → expected:
  - m_valid ×2, both with m_first=1;
  - frame_start ×2, frame_stop ×1.
- 1-cycle (10 ns) glitches on SCL and SDA mid-byte → no extra bits shifted; byte received correctly.
- rstn asserted while the ACK is being driven → sda_t=1 immediately; after release a new 0x58 frame is received correctly.
